// File: rtl/typing_test_pkg.sv
// Shared types and constants for the typing-test game core.
package typing_test_pkg;

  typedef enum logic [1:0] {
    MODE_SELECT = 2'd0,
    MODE_TEST   = 2'd1,
    MODE_CALC   = 2'd2,
    MODE_RESULT = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    PAGE_WPM     = 2'd0,
    PAGE_MISSED  = 2'd1,
    PAGE_ELAPSED = 2'd2
  } page_t;

  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;

  localparam int SECS_PER_MIN = 60;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, start/busy/done handshake.
module seq_divider #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CNT_BITS = $clog2(W + 1);

  logic [W-1:0]        rem_reg;
  logic [W-1:0]        quo_reg;
  logic [CNT_BITS-1:0] cnt_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [W:0]          shifted;
  logic                fits;

  // Dividend bits are shifted out of the quotient register into the remainder.
  always_comb begin
    shifted = {rem_reg, quo_reg[W-1]};
    fits    = (shifted >= {1'b0, divisor});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else if (abort) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else if (start) begin
      rem_reg  <= '0;
      quo_reg  <= dividend;
      cnt_reg  <= CNT_BITS'(W);
      busy_reg <= 1'b1;
      done_reg <= 1'b0;
    end else if (busy_reg) begin
      rem_reg <= fits ? W'(shifted - {1'b0, divisor}) : shifted[W-1:0];
      quo_reg <= {quo_reg[W-2:0], fits};
      cnt_reg <= cnt_reg - 1'b1;
      if (cnt_reg == CNT_BITS'(1)) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end
    end else begin
      done_reg <= 1'b0;
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign quotient = quo_reg;

endmodule

// File: rtl/typing_test_core.sv
// Typing-test game: target entry, word typing with miss/time counting, WPM result pages.
module typing_test_core
  import typing_test_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int TGT_DIGITS = 4,
  parameter int CNT_W      = 16,
  parameter int WPM_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sec_tick,
  input  logic                  key_level,
  input  logic [3:0]            key_code,
  input  logic [4*N_DIGITS-1:0] rand_digits,
  output logic                  rand_req,
  output logic [1:0]            mode,
  output logic [4*N_DIGITS-1:0] disp_digits,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic [CNT_W-1:0]      missed,
  output logic [CNT_W-1:0]      elapsed,
  output logic [CNT_W-1:0]      completed,
  output logic [WPM_W-1:0]      wpm,
  output logic                  done
);

  localparam int MUL_W   = $clog2(SECS_PER_MIN + 1);
  localparam int DIV_W   = CNT_W + MUL_W;
  localparam int EXT_W   = DIV_W + WPM_W;
  localparam int CUR_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VAL_W   = max3(4 * N_DIGITS, CNT_W, WPM_W);
  localparam int TGT_OFF = TGT_DIGITS - N_DIGITS;
  localparam logic [CUR_W-1:0] LAST_CUR = CUR_W'(N_DIGITS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  mode_t                   state_reg, state_next;
  page_t                   page_reg, page_next;
  logic                    key_prev_reg, key_evt_reg;
  logic [3:0]              key_code_reg;
  logic [4*TGT_DIGITS-1:0] tgt_reg, tgt_next;
  logic [4*N_DIGITS-1:0]   word_reg, word_next;
  logic [CUR_W-1:0]        cursor_reg, cursor_next;
  logic [N_DIGITS-1:0]     en_reg, en_next;
  logic [CNT_W-1:0]        missed_reg, missed_next;
  logic [CNT_W-1:0]        elapsed_reg, elapsed_next;
  logic [CNT_W-1:0]        completed_reg, completed_next;
  logic [WPM_W-1:0]        wpm_reg, wpm_next;
  logic                    div_start_reg, div_start_next;
  logic                    div_abort, div_busy, div_done;
  logic [DIV_W-1:0]        div_dividend, div_divisor, div_quotient;
  logic [EXT_W-1:0]        quo_ext;
  logic [WPM_W-1:0]        wpm_sat;
  logic [31:0]             target;
  logic [3:0]              cur_digit;
  logic                    start_test, rand_req_c;
  logic [VAL_W-1:0]        sel_val;
  logic [4*N_DIGITS-1:0]   disp;

  // Key events are edge-detected and registered, so they act one cycle after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev_reg <= 1'b0;
      key_evt_reg  <= 1'b0;
      key_code_reg <= '0;
    end else begin
      key_prev_reg <= key_level;
      key_evt_reg  <= key_level & ~key_prev_reg;
      key_code_reg <= key_code;
    end
  end

  always_comb begin
    target = '0;
    for (int j = 0; j < TGT_DIGITS; j++) begin
      target = target * 32'd10 + 32'(tgt_reg[4*j +: 4]);
    end
  end

  assign cur_digit    = word_reg[4*cursor_reg +: 4];
  assign div_dividend = DIV_W'(completed_reg) * DIV_W'(SECS_PER_MIN);
  assign div_divisor  = (elapsed_reg == '0) ? DIV_W'(1) : DIV_W'(elapsed_reg);
  assign quo_ext      = EXT_W'(div_quotient);
  assign wpm_sat      = (quo_ext > EXT_W'({WPM_W{1'b1}})) ? '1 : quo_ext[WPM_W-1:0];

  seq_divider #(.W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_reg & ~div_busy),
    .abort    (div_abort),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= MODE_SELECT;
      page_reg      <= PAGE_WPM;
      tgt_reg       <= '0;
      word_reg      <= '0;
      cursor_reg    <= '0;
      en_reg        <= '1;
      missed_reg    <= '0;
      elapsed_reg   <= '0;
      completed_reg <= '0;
      wpm_reg       <= '0;
      div_start_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      page_reg      <= page_next;
      tgt_reg       <= tgt_next;
      word_reg      <= word_next;
      cursor_reg    <= cursor_next;
      en_reg        <= en_next;
      missed_reg    <= missed_next;
      elapsed_reg   <= elapsed_next;
      completed_reg <= completed_next;
      wpm_reg       <= wpm_next;
      div_start_reg <= div_start_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    page_next      = page_reg;
    tgt_next       = tgt_reg;
    word_next      = word_reg;
    cursor_next    = cursor_reg;
    en_next        = en_reg;
    missed_next    = missed_reg;
    elapsed_next   = elapsed_reg;
    completed_next = completed_reg;
    wpm_next       = wpm_reg;
    div_start_next = 1'b0;
    div_abort      = 1'b0;
    start_test     = 1'b0;
    rand_req_c     = 1'b0;

    case (state_reg)
      MODE_SELECT: begin
        if (key_evt_reg) begin
          if (key_code_reg <= 4'd9) begin
            for (int j = 0; j < TGT_DIGITS - 1; j++) begin
              tgt_next[4*j +: 4] = tgt_reg[4*(j+1) +: 4];
            end
            tgt_next[4*(TGT_DIGITS-1) +: 4] = key_code_reg;
          end else if (key_code_reg == KEY_A && target != '0) begin
            start_test = 1'b1;
          end
        end
      end
      MODE_TEST: begin
        if (sec_tick) elapsed_next = sat_inc(elapsed_reg);
        if (key_evt_reg && key_code_reg != KEY_B) begin
          if (key_code_reg == cur_digit) begin
            if (cursor_reg == LAST_CUR) begin
              completed_next = sat_inc(completed_reg);
              en_next        = '1;
              cursor_next    = '0;
              if (32'(completed_next) == target) begin
                state_next     = MODE_CALC;
                div_start_next = 1'b1;
              end else begin
                rand_req_c = 1'b1;
                word_next  = rand_digits;
              end
            end else begin
              en_next[cursor_reg] = 1'b0;
              cursor_next         = cursor_reg + 1'b1;
            end
          end else begin
            missed_next = sat_inc(missed_reg);
          end
        end
      end
      MODE_CALC: begin
        if (div_done) begin
          wpm_next   = wpm_sat;
          page_next  = PAGE_WPM;
          state_next = MODE_RESULT;
        end
      end
      MODE_RESULT: begin
        if (key_evt_reg) begin
          if (key_code_reg == KEY_C) begin
            case (page_reg)
              PAGE_WPM:    page_next = PAGE_MISSED;
              PAGE_MISSED: page_next = PAGE_ELAPSED;
              default:     page_next = PAGE_WPM;
            endcase
          end else if (key_code_reg == KEY_A) begin
            start_test = 1'b1;
          end
        end
      end
      default: state_next = MODE_SELECT;
    endcase

    if (start_test) begin
      rand_req_c     = 1'b1;
      word_next      = rand_digits;
      cursor_next    = '0;
      en_next        = '1;
      missed_next    = '0;
      elapsed_next   = '0;
      completed_next = '0;
      state_next     = MODE_TEST;
    end

    // Abort wins over everything, including a divide in flight.
    if (key_evt_reg && key_code_reg == KEY_B) begin
      state_next     = MODE_SELECT;
      word_next      = word_reg;
      cursor_next    = '0;
      en_next        = '1;
      missed_next    = '0;
      elapsed_next   = '0;
      completed_next = '0;
      div_start_next = 1'b0;
      div_abort      = 1'b1;
      rand_req_c     = 1'b0;
    end
  end

  always_comb begin
    disp = '0;
    case (page_reg)
      PAGE_MISSED:  sel_val = VAL_W'(missed_reg);
      PAGE_ELAPSED: sel_val = VAL_W'(elapsed_reg);
      default:      sel_val = VAL_W'(wpm_reg);
    endcase
    case (state_reg)
      MODE_SELECT: begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (i + TGT_OFF >= 0) disp[4*i +: 4] = tgt_reg[4*(i+TGT_OFF) +: 4];
        end
      end
      MODE_RESULT: begin
        for (int i = 0; i < N_DIGITS; i++) begin
          disp[4*i +: 4] = sel_val[4*(N_DIGITS-1-i) +: 4];
        end
      end
      default: disp = word_reg;
    endcase
  end

  assign rand_req    = rand_req_c;
  assign mode        = state_reg;
  assign disp_digits = disp;
  assign digit_en    = en_reg;
  assign missed      = missed_reg;
  assign elapsed     = elapsed_reg;
  assign completed   = completed_reg;
  assign wpm         = wpm_reg;
  assign done        = (state_reg == MODE_RESULT);

endmodule

// File: tb/tb_typing_test_core.sv
// Self-checking bench for typing_test_core: directed scenarios plus randomized games vs a word-level model.
module tb_typing_test_core;
  import typing_test_pkg::*;

  localparam int CALC_LAT = 16 + 6 + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sec_tick = 1'b0;
  logic        key_level = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] rand_digits = 16'h0;
  logic        rand_req;
  logic [1:0]  mode;
  logic [15:0] disp_digits;
  logic [3:0]  digit_en;
  logic [15:0] missed, elapsed, completed, wpm;
  logic        done;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int m_buf[4];
  int m_missed, m_elapsed;

  typing_test_core dut (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .key_level(key_level),
    .key_code(key_code), .rand_digits(rand_digits), .rand_req(rand_req),
    .mode(mode), .disp_digits(disp_digits), .digit_en(digit_en),
    .missed(missed), .elapsed(elapsed), .completed(completed),
    .wpm(wpm), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rand_req === 1'b1) req_cnt <= req_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model helpers ----------------
  task automatic model_shift(input int d);
    for (int i = 0; i < 3; i++) m_buf[i] = m_buf[i+1];
    m_buf[3] = d;
  endtask

  function automatic int model_target();
    return m_buf[0] * 1000 + m_buf[1] * 100 + m_buf[2] * 10 + m_buf[3];
  endfunction

  function automatic logic [15:0] buf_disp();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) d[4*i +: 4] = 4'(m_buf[i]);
    return d;
  endfunction

  function automatic logic [15:0] hex_disp(input logic [15:0] v);
    logic [15:0] d;
    for (int i = 0; i < 4; i++) d[4*i +: 4] = v[4*(3-i) +: 4];
    return d;
  endfunction

  function automatic int exp_wpm(input int c, input int e);
    int q;
    q = (c * 60) / ((e == 0) ? 1 : e);
    return (q > 65535) ? 65535 : q;
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
    return w;
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic press(input logic [3:0] code);
    @(negedge clk); key_code = code; key_level = 1'b1;
    @(negedge clk); key_level = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_tick(input logic [3:0] code);
    @(negedge clk); key_code = code; key_level = 1'b1;
    @(negedge clk); key_level = 1'b0; sec_tick = 1'b1;
    @(negedge clk); sec_tick = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk); sec_tick = 1'b1;
    @(negedge clk); sec_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_buf[i] = 0;
  endtask

  task automatic enter_target(input int t);
    int d[4];
    d[0] = (t / 1000) % 10; d[1] = (t / 100) % 10; d[2] = (t / 10) % 10; d[3] = t % 10;
    for (int i = 0; i < 4; i++) begin
      press(4'(d[i]));
      model_shift(d[i]);
    end
  endtask

  task automatic type_word(input logic [15:0] w, input logic [15:0] next_w,
                           input int wrong_pct, input int max_ticks);
    int d, k, r;
    for (int i = 0; i < 4; i++) begin
      d = int'(w[4*i +: 4]);
      if ($urandom_range(0, 99) < wrong_pct) begin
        r = $urandom_range(0, 10);
        if (r == d) r = (d + 1) % 10;
        press(4'(r));
        m_missed++;
      end
      k = (max_ticks > 0) ? $urandom_range(0, max_ticks) : 0;
      repeat (k) tick();
      m_elapsed += k;
      if (i == 3) rand_digits = next_w;
      press(4'(d));
    end
  endtask

  task automatic wait_result(output int calc_cyc, output bit ok);
    calc_cyc = 0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (mode == 2'd3) begin
        ok = 1'b1;
        break;
      end
      if (mode == 2'd2) calc_cyc++;
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d exp 0", mode); end
    checks++; if (missed !== 16'd0 || elapsed !== 16'd0 || completed !== 16'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d/%0d exp 0/0/0", missed, elapsed, completed); end
    checks++; if (wpm !== 16'd0 || done !== 1'b0 || rand_req !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got wpm=%0d done=%0d req=%0d exp 0", wpm, done, rand_req); end
    checks++; if (digit_en !== 4'hF) begin errors++; $display("FAIL reset_digit_en got %h exp f", digit_en); end
    checks++; if (disp_digits !== 16'h0) begin errors++; $display("FAIL reset_disp got %h exp 0000", disp_digits); end
  endtask

  task automatic test_start();
    int base;
    enter_target(2);
    checks++; if (disp_digits !== buf_disp()) begin
      errors++; $display("FAIL select_disp got %h exp %h", disp_digits, buf_disp()); end
    rand_digits = 16'h4321;
    base = req_cnt;
    press(KEY_A);
    checks++; if (mode !== 2'd1) begin errors++; $display("FAIL start_mode got %0d exp 1", mode); end
    checks++; if (req_cnt - base !== 1) begin errors++; $display("FAIL start_rand_req got %0d exp 1", req_cnt - base); end
    checks++; if (disp_digits !== 16'h4321) begin errors++; $display("FAIL start_disp got %h exp 4321", disp_digits); end
    press(4'd1); press(4'd2); press(4'd3);
    checks++; if (digit_en !== 4'b1000) begin errors++; $display("FAIL cursor_en got %b exp 1000", digit_en); end
  endtask

  task automatic test_directed_wpm();
    int cyc; bit ok;
    rand_digits = 16'h8765;
    press(4'd4);
    checks++; if (completed !== 16'd1 || digit_en !== 4'hF || disp_digits !== 16'h8765) begin
      errors++; $display("FAIL word1_done got c=%0d en=%h disp=%h exp 1/f/8765", completed, digit_en, disp_digits); end
    press(4'd9);
    repeat (30) tick();
    press(4'd5); press(4'd6); press(4'd7); press(4'd8);
    checks++; if (mode !== 2'd2) begin errors++; $display("FAIL enter_calc got %0d exp 2", mode); end
    checks++; if (completed !== 16'd2 || missed !== 16'd1 || elapsed !== 16'd30) begin
      errors++; $display("FAIL directed_counts got %0d/%0d/%0d exp 2/1/30", completed, missed, elapsed); end
    wait_result(cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL directed_result_timeout got mode=%0d exp 3", mode); end
    checks++; if (cyc !== CALC_LAT) begin errors++; $display("FAIL calc_latency got %0d exp %0d", cyc, CALC_LAT); end
    checks++; if (wpm !== 16'd4 || done !== 1'b1) begin errors++; $display("FAIL directed_wpm got %0d done=%0d exp 4/1", wpm, done); end
  endtask

  task automatic test_pages();
    logic [15:0] pages[4];
    pages[0] = 16'd4; pages[1] = 16'd1; pages[2] = 16'd30; pages[3] = 16'd4;
    for (int p = 0; p < 4; p++) begin
      if (p > 0) press(KEY_C);
      checks++; if (disp_digits !== hex_disp(pages[p])) begin
        errors++; $display("FAIL page_%0d got %h exp %h", p, disp_digits, hex_disp(pages[p])); end
    end
    tick();
    checks++; if (elapsed !== 16'd30 || mode !== 2'd3) begin
      errors++; $display("FAIL result_frozen got el=%0d mode=%0d exp 30/3", elapsed, mode); end
  endtask

  task automatic test_no_tick();
    int cyc; bit ok;
    logic [15:0] w;
    press(KEY_B);
    checks++; if (mode !== 2'd0 || completed !== 16'd0 || done !== 1'b0 || disp_digits !== buf_disp()) begin
      errors++; $display("FAIL abort_result got mode=%0d c=%0d disp=%h exp 0/0/%h", mode, completed, disp_digits, buf_disp()); end
    enter_target(1);
    w = rand_word();
    rand_digits = w;
    m_missed = 0; m_elapsed = 0;
    press(KEY_A);
    type_word(w, rand_word(), 0, 0);
    wait_result(cyc, ok);
    checks++; if (!ok || elapsed !== 16'd0 || wpm !== 16'd60) begin
      errors++; $display("FAIL zero_elapsed got ok=%0d el=%0d wpm=%0d exp 1/0/60", ok, elapsed, wpm); end
  endtask

  task automatic test_key_hold();
    press(KEY_B);
    @(negedge clk); key_code = 4'd5; key_level = 1'b1;
    repeat (100) @(negedge clk);
    key_level = 1'b0;
    @(negedge clk); @(negedge clk);
    model_shift(5);
    checks++; if (disp_digits !== buf_disp()) begin
      errors++; $display("FAIL key_hold got %h exp %h", disp_digits, buf_disp()); end
  endtask

  task automatic test_tick_and_key();
    rand_digits = 16'h4321;
    press(KEY_A);
    press_tick(4'd9);
    checks++; if (missed !== 16'd1 || elapsed !== 16'd1) begin
      errors++; $display("FAIL tick_wrong_key got %0d/%0d exp 1/1", missed, elapsed); end
    press_tick(4'd1);
    checks++; if (missed !== 16'd1 || elapsed !== 16'd2 || digit_en !== 4'b1110) begin
      errors++; $display("FAIL tick_right_key got %0d/%0d en=%b exp 1/2/1110", missed, elapsed, digit_en); end
  endtask

  task automatic test_reset_mid_test();
    do_reset();
    checks++; if (mode !== 2'd0 || missed !== 16'd0 || digit_en !== 4'hF || disp_digits !== 16'h0) begin
      errors++; $display("FAIL reset_mid_test got mode=%0d m=%0d en=%h disp=%h exp 0/0/f/0000", mode, missed, digit_en, disp_digits); end
  endtask

  task automatic test_b_during_calc();
    logic [15:0] w;
    enter_target(1);
    w = rand_word();
    rand_digits = w;
    press(KEY_A);
    type_word(w, rand_word(), 0, 1);
    checks++; if (mode !== 2'd2) begin errors++; $display("FAIL calc_before_abort got %0d exp 2", mode); end
    press(KEY_B);
    checks++; if (mode !== 2'd0 || completed !== 16'd0 || elapsed !== 16'd0 || disp_digits !== buf_disp()) begin
      errors++; $display("FAIL abort_calc got mode=%0d c=%0d el=%0d disp=%h exp 0/0/0/%h", mode, completed, elapsed, disp_digits, buf_disp()); end
    repeat (30) @(negedge clk);
    checks++; if (mode !== 2'd0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_stays got mode=%0d done=%0d exp 0/0", mode, done); end
  endtask

  task automatic test_random_games();
    int t, cyc, base;
    bit ok;
    logic [15:0] w, nw;
    for (int r = 0; r < 8; r++) begin
      t = $urandom_range(1, 3);
      if (!(mode == 2'd3 && t == model_target())) begin
        press(KEY_B);
        enter_target(t);
      end
      if ($urandom_range(0, 1) == 1) tick();
      m_missed = 0; m_elapsed = 0;
      w = rand_word();
      rand_digits = w;
      base = req_cnt;
      press(KEY_A);
      for (int k = 0; k < t; k++) begin
        nw = rand_word();
        type_word(w, nw, 25, 2);
        w = nw;
      end
      wait_result(cyc, ok);
      checks++; if (!ok || cyc !== CALC_LAT) begin
        errors++; $display("FAIL rand%0d_latency got ok=%0d cyc=%0d exp 1/%0d", r, ok, cyc, CALC_LAT); end
      checks++; if (completed !== 16'(t) || req_cnt - base !== t) begin
        errors++; $display("FAIL rand%0d_words got c=%0d req=%0d exp %0d/%0d", r, completed, req_cnt - base, t, t); end
      checks++; if (missed !== 16'(m_missed) || elapsed !== 16'(m_elapsed)) begin
        errors++; $display("FAIL rand%0d_counts got %0d/%0d exp %0d/%0d", r, missed, elapsed, m_missed, m_elapsed); end
      checks++; if (wpm !== 16'(exp_wpm(t, m_elapsed)) || done !== 1'b1) begin
        errors++; $display("FAIL rand%0d_wpm got %0d done=%0d exp %0d/1", r, wpm, done, exp_wpm(t, m_elapsed)); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_directed_wpm();
    test_pages();
    test_no_tick();
    test_key_hold();
    test_tick_and_key();
    test_reset_mid_test();
    test_b_during_calc();
    test_random_games();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
